// File: rtl/branch_ctrl_if.sv
// Pipeline-facing signal bundle for the branch controller: ID prediction,
// EX resolution, redirect/flush controls and branch statistics.
interface branch_ctrl_if;
   logic        stall;
   logic        id_valid;
   logic        id_is_branch;
   logic [31:0] id_pc;
   logic        id_pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic        ex_bra_taken;
   logic        ex_pred_taken;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic [31:0] ex_pc_plus4;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   modport master (
      output stall, id_valid, id_is_branch, id_pc,
             ex_valid, ex_is_branch, ex_is_jump, ex_bra_taken, ex_pred_taken,
             ex_pc, ex_target, ex_pc_plus4,
      input  id_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
             branch_cnt, mispredict_cnt
   );

   modport slave (
      input  stall, id_valid, id_is_branch, id_pc,
             ex_valid, ex_is_branch, ex_is_jump, ex_bra_taken, ex_pred_taken,
             ex_pc, ex_target, ex_pc_plus4,
      output id_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
             branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// Branch sequencing controller: 2-bit-counter BHT prediction in ID, EX-stage
// resolution driving PC redirect and flushes, recovery window and statistics.
module branch_ctrl #(
   parameter int BHT_ENTRIES = 16,
   parameter int IDX_W       = $clog2(BHT_ENTRIES),
   parameter int IMEM_LAT    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   branch_ctrl_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, RECOVER = 1'b1} state_t;

   localparam logic [2:0] LAT_C     = 3'(IMEM_LAT);
   localparam bit         HAS_LAT_C = (IMEM_LAT > 0);

   state_t           state_r;
   logic [2:0]       rcnt_r;
   logic [1:0]       bht_r [BHT_ENTRIES];
   logic [31:0]      branch_cnt_r;
   logic [31:0]      mispredict_cnt_r;

   logic [IDX_W-1:0] id_idx_s;
   logic [IDX_W-1:0] ex_idx_s;
   logic             resolve_s;
   logic             br_resolve_s;
   logic             mispredict_s;
   logic             fire_s;
   logic             recover_s;
   logic             pred_s;
   logic [31:0]      redirect_pc_s;
   logic             unused_s;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      case ({taken, cnt})
         3'b1_11: nxt = 2'b11;
         3'b0_00: nxt = 2'b00;
         default: nxt = taken ? (cnt + 2'b01) : (cnt - 2'b01);
      endcase
      return nxt;
   endfunction

   assign id_idx_s     = bus.id_pc[IDX_W+1:2];
   assign ex_idx_s     = bus.ex_pc[IDX_W+1:2];
   assign unused_s     = ^{bus.id_pc[31:IDX_W+2], bus.id_pc[1:0],
                           bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

   assign resolve_s    = bus.ex_valid & ~bus.stall;
   assign br_resolve_s = resolve_s & bus.ex_is_branch;
   assign mispredict_s = br_resolve_s & (bus.ex_bra_taken != bus.ex_pred_taken);
   assign fire_s       = mispredict_s | (resolve_s & bus.ex_is_jump);
   assign recover_s    = (state_r == RECOVER);

   // Prediction reads the pre-update counter; suppressed while the pipe is being redirected.
   assign pred_s = bus.id_valid & bus.id_is_branch & bht_r[id_idx_s][1] & ~fire_s & ~recover_s;

   // Corrected fetch address on a fire, zero otherwise.
   always_comb begin
      redirect_pc_s = 32'h0000_0000;
      if (fire_s) begin
         if (bus.ex_is_jump | bus.ex_bra_taken) begin
            redirect_pc_s = bus.ex_target;
         end else begin
            redirect_pc_s = bus.ex_pc_plus4;
         end
      end else begin
         redirect_pc_s = 32'h0000_0000;
      end
   end

   assign bus.id_pred_taken  = pred_s;
   assign bus.redirect_valid = fire_s;
   assign bus.redirect_pc    = redirect_pc_s;
   assign bus.flush_id_ex    = fire_s;
   assign bus.flush_if_id    = fire_s | recover_s | pred_s;
   assign bus.branch_cnt     = branch_cnt_r;
   assign bus.mispredict_cnt = mispredict_cnt_r;

   // BHT counters train on every resolved conditional branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_r[i] <= 2'b01;
         end
      end else if (br_resolve_s) begin
         bht_r[ex_idx_s] <= sat_update(bht_r[ex_idx_s], bus.ex_bra_taken);
      end
   end

   // Branch and mispredict statistics, free-running with wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_r     <= 32'h0000_0000;
         mispredict_cnt_r <= 32'h0000_0000;
      end else begin
         if (br_resolve_s) begin
            branch_cnt_r <= branch_cnt_r + 32'h0000_0001;
         end
         if (mispredict_s) begin
            mispredict_cnt_r <= mispredict_cnt_r + 32'h0000_0001;
         end
      end
   end

   // Recovery FSM: holds the window open for the instruction-memory latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         rcnt_r  <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (fire_s && HAS_LAT_C) begin
                  state_r <= RECOVER;
                  rcnt_r  <= LAT_C;
               end
            end
            RECOVER: begin
               if (fire_s) begin
                  rcnt_r <= LAT_C;
               end else if (!bus.stall) begin
                  if (rcnt_r <= 3'd1) begin
                     state_r <= IDLE;
                     rcnt_r  <= 3'd0;
                  end else begin
                     rcnt_r <= rcnt_r - 3'd1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               rcnt_r  <= 3'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed, table-driven bench for branch_ctrl (16-entry BHT, IMEM_LAT=1).
module tb_branch_ctrl;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   branch_ctrl_if bus ();

   branch_ctrl #(.BHT_ENTRIES(16), .IMEM_LAT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        id_v;
      logic        id_br;
      logic [31:0] id_pc;
      logic        ex_v;
      logic        ex_br;
      logic        ex_jmp;
      logic        ex_tk;
      logic        ex_pd;
      logic [31:0] ex_pc;
      logic [31:0] ex_tgt;
      logic [31:0] ex_p4;
      logic        e_pred;
      logic        e_rv;
      logic [31:0] e_rpc;
      logic        e_fif;
      logic        e_fie;
      logic [31:0] e_bcnt;
      logic [31:0] e_mcnt;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.stall         = v.stall;
      bus.id_valid      = v.id_v;
      bus.id_is_branch  = v.id_br;
      bus.id_pc         = v.id_pc;
      bus.ex_valid      = v.ex_v;
      bus.ex_is_branch  = v.ex_br;
      bus.ex_is_jump    = v.ex_jmp;
      bus.ex_bra_taken  = v.ex_tk;
      bus.ex_pred_taken = v.ex_pd;
      bus.ex_pc         = v.ex_pc;
      bus.ex_target     = v.ex_tgt;
      bus.ex_pc_plus4   = v.ex_p4;
   endtask

   task automatic idle_inputs();
      bus.stall = 1'b0; bus.id_valid = 1'b0; bus.id_is_branch = 1'b0; bus.id_pc = 32'h0;
      bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_is_jump = 1'b0;
      bus.ex_bra_taken = 1'b0; bus.ex_pred_taken = 1'b0; bus.ex_pc = 32'h0;
      bus.ex_target = 32'h0; bus.ex_pc_plus4 = 32'h0;
   endtask

   task automatic check_outs(input string tag, input logic pred, input logic rv,
                             input logic [31:0] rpc, input logic fif, input logic fie,
                             input logic [31:0] bcnt, input logic [31:0] mcnt);
      chk({tag, " id_pred_taken"},  {31'h0, bus.id_pred_taken},  {31'h0, pred});
      chk({tag, " redirect_valid"}, {31'h0, bus.redirect_valid}, {31'h0, rv});
      chk({tag, " redirect_pc"},    bus.redirect_pc,             rpc);
      chk({tag, " flush_if_id"},    {31'h0, bus.flush_if_id},    {31'h0, fif});
      chk({tag, " flush_id_ex"},    {31'h0, bus.flush_id_ex},    {31'h0, fie});
      chk({tag, " branch_cnt"},     bus.branch_cnt,              bcnt);
      chk({tag, " mispredict_cnt"}, bus.mispredict_cnt,          mcnt);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      // stall,idv,idbr,id_pc, exv,exbr,jmp,tk,pd,ex_pc,tgt,p4, pred,rv,rpc,fif,fie,bcnt,mcnt
      tbl[0]  = '{1'b0,1'b0,1'b0,32'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd0,32'd0};
      tbl[1]  = '{1'b0,1'b0,1'b0,32'h00, 1'b1,1'b1,1'b0,1'b1,1'b0,32'h40,32'h080,32'h44, 1'b0,1'b1,32'h080,1'b1,1'b1,32'd0,32'd0};
      tbl[2]  = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b0,1'b0,32'h000,1'b1,1'b0,32'd1,32'd1};
      tbl[3]  = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b1,1'b0,32'h000,1'b1,1'b0,32'd1,32'd1};
      tbl[4]  = '{1'b0,1'b1,1'b1,32'h40, 1'b1,1'b1,1'b0,1'b1,1'b1,32'h40,32'h080,32'h44, 1'b1,1'b0,32'h000,1'b1,1'b0,32'd1,32'd1};
      tbl[5]  = '{1'b0,1'b0,1'b0,32'h00, 1'b1,1'b1,1'b0,1'b1,1'b1,32'h40,32'h080,32'h44, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd2,32'd1};
      tbl[6]  = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b1,1'b0,32'h000,1'b1,1'b0,32'd3,32'd1};
      tbl[7]  = '{1'b0,1'b0,1'b0,32'h00, 1'b1,1'b1,1'b0,1'b1,1'b1,32'h40,32'h080,32'h44, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd3,32'd1};
      tbl[8]  = '{1'b0,1'b0,1'b0,32'h00, 1'b1,1'b1,1'b0,1'b0,1'b1,32'h40,32'h080,32'h44, 1'b0,1'b1,32'h044,1'b1,1'b1,32'd4,32'd1};
      tbl[9]  = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b0,1'b0,32'h000,1'b1,1'b0,32'd5,32'd2};
      tbl[10] = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b1,1'b0,32'h000,1'b1,1'b0,32'd5,32'd2};
      tbl[11] = '{1'b0,1'b1,1'b1,32'h40, 1'b1,1'b0,1'b1,1'b0,1'b0,32'h40,32'h100,32'h44, 1'b0,1'b1,32'h100,1'b1,1'b1,32'd5,32'd2};
      tbl[12] = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b0,1'b0,32'h000,1'b1,1'b0,32'd5,32'd2};
      tbl[13] = '{1'b0,1'b1,1'b1,32'h40, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b1,1'b0,32'h000,1'b1,1'b0,32'd5,32'd2};
      tbl[14] = '{1'b0,1'b0,1'b0,32'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,32'h40,32'h080,32'h44, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd5,32'd2};
      tbl[15] = '{1'b0,1'b1,1'b1,32'h44, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd5,32'd2};
      tbl[16] = '{1'b0,1'b0,1'b0,32'h00, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h48,32'h080,32'h4c, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd5,32'd2};
      tbl[17] = '{1'b0,1'b1,1'b1,32'h4c, 1'b1,1'b1,1'b0,1'b1,1'b1,32'h4c,32'h080,32'h50, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd6,32'd2};
      tbl[18] = '{1'b0,1'b1,1'b1,32'h4c, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b1,1'b0,32'h000,1'b1,1'b0,32'd7,32'd2};
      tbl[19] = '{1'b0,1'b0,1'b0,32'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h000,32'h00, 1'b0,1'b0,32'h000,1'b0,1'b0,32'd7,32'd2};

      // Reset state, with a live ID branch to probe the reset BHT value.
      idle_inputs();
      rst_n = 1'b0;
      bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_pc = 32'h40;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         apply(tbl[i]);
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), tbl[i].e_pred, tbl[i].e_rv, tbl[i].e_rpc,
                    tbl[i].e_fif, tbl[i].e_fie, tbl[i].e_bcnt, tbl[i].e_mcnt);
      end

      // Mispredict held under stall: nothing happens until stall drops.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         idle_inputs();
         bus.stall = 1'b1; bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1;
         bus.ex_bra_taken = 1'b1; bus.ex_pred_taken = 1'b0; bus.ex_pc = 32'h44;
         bus.ex_target = 32'h200; bus.ex_pc_plus4 = 32'h48;
         @(negedge clk);
         check_outs($sformatf("stall%0d", k), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd7, 32'd2);
      end
      @(posedge clk);
      #1;
      bus.stall = 1'b0;
      @(negedge clk);
      check_outs("stall_release", 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'd7, 32'd2);
      // Recovery counter must hold while stalled in RECOVER.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         idle_inputs();
         bus.stall = (k < 2) ? 1'b1 : 1'b0;
         @(negedge clk);
         check_outs($sformatf("rec_hold%0d", k), 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd8, 32'd3);
      end
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      check_outs("rec_done", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd8, 32'd3);

      // Asynchronous reset in the middle of RECOVER.
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_bra_taken = 1'b0;
      bus.ex_pred_taken = 1'b1; bus.ex_pc = 32'h40; bus.ex_target = 32'h80;
      bus.ex_pc_plus4 = 32'h44;
      @(negedge clk);
      check_outs("pre_rst_fire", 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'd8, 32'd3);
      @(posedge clk);
      #1;
      idle_inputs();
      bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_pc = 32'h40;
      @(negedge clk);
      check_outs("pre_rst_rec", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd9, 32'd4);
      #1;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int p = 0; p < 16; p++) begin
         bus.id_pc = 32'(p * 4);
         #1;
         chk($sformatf("post_rst pred pc%0d", p * 4), {31'h0, bus.id_pred_taken}, 32'h0);
      end
      @(posedge clk);
      #1;
      bus.id_pc = 32'h40;
      @(negedge clk);
      check_outs("post_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
